// File: rtl/frame_writer.sv
// Frame writer: takes rendered pixels over valid/ready, writes them into the back
// buffer at y*DISPLAY_WIDTH+x, and requests a buffer swap in vblank once a frame is full.
module frame_writer #(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int ADDR_BITS      = 19,
  parameter int COLOR_WIDTH    = 4,
  parameter int X_BITS         = 10,
  parameter int Y_BITS         = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  input  logic [X_BITS-1:0]      pixel_x,
  input  logic [Y_BITS-1:0]      pixel_y,
  input  logic [COLOR_WIDTH-1:0] pixel_color,
  input  logic                   vblank_in,
  output logic                   write_enable,
  output logic [ADDR_BITS-1:0]   write_addr,
  output logic [COLOR_WIDTH-1:0] write_data,
  output logic                   swap_buffers,
  output logic                   frame_done_out,
  output logic [15:0]            frame_count_out,
  output logic                   range_error_out
);

  localparam int FRAME_PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int CNT_BITS     = $clog2(FRAME_PIXELS + 1);

  typedef enum logic [1:0] {
    ACCEPT,
    WAIT_VBLANK,
    SWAP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_BITS-1:0] pixel_count;
  logic                transfer;
  logic                in_range;
  logic                frame_last;

  assign pixel_ready = (state == ACCEPT);
  assign transfer    = pixel_valid && pixel_ready;
  assign in_range    = (32'(pixel_x) < 32'(DISPLAY_WIDTH)) &&
                       (32'(pixel_y) < 32'(DISPLAY_HEIGHT));
  assign frame_last  = (32'(pixel_count) == 32'(FRAME_PIXELS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCEPT;
    else        state <= state_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    swap_buffers = 1'b0;
    case (state)
      ACCEPT: begin
        if (transfer && in_range && frame_last) state_next = WAIT_VBLANK;
      end
      WAIT_VBLANK: begin
        if (vblank_in) state_next = SWAP;
      end
      SWAP: begin
        swap_buffers = 1'b1;
        state_next   = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
  end

  assign frame_done_out = swap_buffers;

  // The last pixel's write issues the cycle after its transfer, while the FSM is
  // already in WAIT_VBLANK, so it always lands before the swap pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_count     <= '0;
      write_enable    <= 1'b0;
      write_addr      <= '0;
      write_data      <= '0;
      frame_count_out <= '0;
      range_error_out <= 1'b0;
    end else begin
      write_enable <= transfer && in_range;
      if (transfer && in_range) begin
        write_addr  <= ADDR_BITS'(32'(pixel_y) * 32'(DISPLAY_WIDTH) + 32'(pixel_x));
        write_data  <= pixel_color;
        pixel_count <= frame_last ? '0 : pixel_count + 1'b1;
      end
      if (transfer && !in_range) range_error_out <= 1'b1;
      if (state == SWAP)         frame_count_out <= frame_count_out + 16'd1;
    end
  end

endmodule
